// File: rtl/mult_unit_pkg.sv
// mult_unit_pkg: shared constants and FSM encoding for the iterative multiplier.
package mult_unit_pkg;
    localparam int MULT_W = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;
endpackage

// File: rtl/mult_abs.sv
// mult_abs: conditional two's-complement negate of a W-bit value.
module mult_abs
    import mult_unit_pkg::*;
#(
    parameter int W = MULT_W
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? -x : x;
endmodule

// File: rtl/mult_unit.sv
// mult_unit: radix-2 shift-add 32x32 multiplier writing HI/LO, stalling the pipeline while busy.
module mult_unit
    import mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    state_t state, next;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] mcand, upper, lower, a_abs, b_abs;
    logic [WIDTH:0] sum;
    logic [2*WIDTH-1:0] res;
    logic neg, last, load;

    mult_abs #(.W(WIDTH)) u_abs_a (.x(a), .neg(is_signed & a[WIDTH-1]), .y(a_abs));
    mult_abs #(.W(WIDTH)) u_abs_b (.x(b), .neg(is_signed & b[WIDTH-1]), .y(b_abs));
    mult_abs #(.W(2*WIDTH)) u_neg_p (.x({upper, lower}), .neg(neg), .y(res));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next;
            busy  <= next != IDLE;
            done  <= state == FIX;
        end
    end

    always_comb begin
        next = state == IDLE ? (start ? CALC : IDLE) :
               state == CALC ? (last ? FIX : CALC) : IDLE;
    end

    always_comb begin
        stall = start | busy;
        load  = state == IDLE && start;
        last  = cnt == CW'(WIDTH - 1);
        sum   = lower[0] ? {1'b0, upper} + {1'b0, mcand} : {1'b0, upper};
    end

    // The multiplier shifts out of the low half as product bits shift in from the carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            upper <= '0;
            lower <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (load) begin
            mcand <= a_abs;
            upper <= '0;
            lower <= b_abs;
            neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt   <= '0;
        end else if (state == CALC) begin
            {upper, lower} <= {sum, lower[WIDTH-1:1]};
            cnt <= cnt + CW'(1);
        end else if (state == FIX) begin
            {hi, lo} <= res;
        end
    end
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: randomized and directed checks of mult_unit against an arithmetic product model.
module tb_mult_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic is_signed = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic busy, stall, done;
    logic [31:0] hi, lo;
    int checks = 0, errors = 0;

    mult_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx, sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Called at a negedge; returns at the negedge where done is high.
    task automatic do_mult(input logic [31:0] x, input logic [31:0] y, input logic s, input int poke);
        logic [63:0] exp = model(x, y, s);
        logic [31:0] old_hi = hi, old_lo = lo;
        bit stall_ok = 1, hold_ok = 1;
        int lat = 0;
        a = x; b = y; is_signed = s; start = 1'b1;
        #1 check("stall_start", stall, 1);
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (lat == poke) begin
                start = 1'b1; a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
            end
            if (!done) begin
                stall_ok &= stall;
                hold_ok &= (hi == old_hi) && (lo == old_lo);
            end
        end while (!done && lat < 60);
        check("latency", lat, 34);
        check("stall_hold", stall_ok, 1);
        check("hilo_hold", hold_ok, 1);
        check("hi", hi, exp[63:32]);
        check("lo", lo, exp[31:0]);
    endtask

    task automatic done_gone;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        logic [31:0] h0, l0;
        int dcount;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hilo", {hi, lo}, 0);
        check("rst_stall", stall, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        check("umax_hi", hi, 32'hFFFFFFFE);
        check("umax_lo", lo, 32'h00000001);
        done_gone();
        @(negedge clk); do_mult(32'hFFFFFFFD, 32'h5, 1, 0);
        check("neg3x5", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        @(negedge clk); do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        check("m1xm1", {hi, lo}, 64'h1);
        @(negedge clk); do_mult(32'h80000000, 32'h80000000, 1, 0);
        check("smin", {hi, lo}, 64'h40000000_00000000);
        @(negedge clk); do_mult(32'h12345678, 32'h9ABCDEF0, 1, 0);
        @(negedge clk); do_mult(32'h80000000, 32'h80000000, 0, 0);
        check("umin", {hi, lo}, 64'h40000000_00000000);
        @(negedge clk); do_mult(32'hDEADBEEF, 32'h0BADF00D, 1, 12);
        done_gone();
        @(negedge clk); do_mult(32'h00001234, 32'hFFFF0000, 0, 0);
        do_mult(32'hFFFFFF00, 32'h00000321, 1, 0);
        done_gone();
        // Reset in the middle of CALC discards the partial product.
        @(negedge clk);
        a = 32'hCAFEF00D; b = 32'h76543210; is_signed = 1'b0; start = 1'b1;
        repeat (11) begin @(negedge clk); start = 1'b0; end
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hilo", {hi, lo}, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin @(negedge clk); dcount += int'(done); end
        check("no_done_after_rst", dcount, 0);
        do_mult(32'd7, 32'd6, 0, 0);
        check("7x6", {hi, lo}, 64'd42);
        @(negedge clk); do_mult(32'h0, 32'hFFFFFFFF, 1, 0);
        check("zero_neg", {hi, lo}, 64'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            do_mult($urandom, $urandom, 1'($urandom_range(0, 1)), 0);
        end
        h0 = hi; l0 = lo;
        dcount = 0;
        repeat (100) begin @(negedge clk); dcount += int'(hi != h0 || lo != l0 || done); end
        check("idle_hold", dcount, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
